// File: rtl/sobel_pkg.sv
// sobel_pkg
//   Shared definitions for the Sobel frame sequencer and its neighbours:
//   FSM state encoding, default frame geometry / pipeline latency, and a
//   width helper used to size counters.
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int IMG_W_DEF    = 32;
  localparam int IMG_H_DEF    = 32;
  localparam int ADDR_W_DEF   = 10;
  localparam int PIPE_LAT_DEF = 2;

  // Bits needed to index n distinct values; never returns less than 1 so a
  // degenerate count still yields a legal vector width.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/sobel_frame_ctrl_if.sv
// sobel_frame_ctrl_if
//   Bundles the frame sequencer's control, RAM read and pixel-tag signals.
//   master : the sequencer (drives rd_en/rd_addr, pixel tags, busy, done)
//   slave  : the surrounding logic (drives start, out_ready)
//   Signals:
//     start      frame start request
//     out_ready  downstream can accept pixels
//     rd_en      frame RAM read strobe
//     rd_addr    frame RAM address
//     pix_valid  RAM data valid this cycle
//     sol/eol    first/last pixel of a line
//     sof/eof    first/last pixel of the frame
//     win_valid  3x3 window complete at this pixel
//     busy       frame in progress (RUN or FLUSH)
//     done       one-cycle frame completion pulse
interface sobel_frame_ctrl_if
  import sobel_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              start;
  logic              out_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              pix_valid;
  logic              sol;
  logic              eol;
  logic              sof;
  logic              eof;
  logic              win_valid;
  logic              busy;
  logic              done;

  modport master (
    input  start, out_ready,
    output rd_en, rd_addr, pix_valid, sol, eol, sof, eof, win_valid, busy, done
  );

  modport slave (
    output start, out_ready,
    input  rd_en, rd_addr, pix_valid, sol, eol, sof, eof, win_valid, busy, done
  );
endinterface

// File: rtl/raster_counter.sv
// raster_counter
//   Raster-order position counter for one frame: col, row and a linear
//   address that simply increments, so no row*IMG_W multiply is needed.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     clear      return col/row/addr to 0 (takes priority over en)
//     en         advance one pixel
//     col, row   current position
//     addr       current linear address
//     last_col   col is at IMG_W-1
//     last_row   row is at IMG_H-1
module raster_counter
  import sobel_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int COL_W  = clog2(IMG_W),
  parameter int ROW_W  = clog2(IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr,
  output logic              last_col,
  output logic              last_row
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

  assign last_col = (col == LAST_COL);
  assign last_row = (row == LAST_ROW);

  // Column wraps into the next row; the row wraps to 0 after the final line
  // so the counter is already back at the origin when the frame ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (clear) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (en) begin
      addr <= addr + ADDR_W'(1);
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl
//   Frame sequencer for the Sobel datapath. A start pulse in IDLE walks the
//   frame RAM in raster order, one read per cycle while out_ready is high.
//   Each returned pixel (one cycle after its read) is tagged with line/frame
//   and 3x3-window flags. After the last read the FSM waits for the Sobel
//   pipeline to drain and then pulses done.
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous reset, active high; aborts a frame without done
//     bus   sobel_frame_ctrl_if.master: start, out_ready in; rd_en, rd_addr,
//           pix_valid, sol, eol, sof, eof, win_valid, busy, done out
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  sobel_frame_ctrl_if.master  bus
);

  localparam int COL_W   = clog2(IMG_W);
  localparam int ROW_W   = clog2(IMG_H);
  localparam int FLUSH_W = clog2(PIPE_LAT + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(PIPE_LAT);

  state_t              state;
  logic [FLUSH_W-1:0]  flush_cnt;

  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic [ADDR_W-1:0]   addr;
  logic                last_col;
  logic                last_row;

  logic                issue;
  logic                cnt_clear;
  logic                last_issue;

  logic                rd_en_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                iss_sol, iss_eol, iss_sof, iss_eof, iss_win;
  logic                pix_valid_q, sol_q, eol_q, sof_q, eof_q, win_q;
  logic                busy_q;
  logic                done_q;

  // A read is issued on the start edge itself when downstream is ready, and
  // on every ready edge in RUN. FLUSH ignores out_ready entirely.
  always_comb begin
    issue = 1'b0;
    case (state)
      ST_IDLE: issue = bus.start && bus.out_ready;
      ST_RUN:  issue = bus.out_ready;
      default: issue = 1'b0;
    endcase
  end

  // Outside RUN the counter is parked at the origin, so the first read of a
  // frame always comes from address 0 regardless of how the last one ended.
  assign cnt_clear  = !issue && (state != ST_RUN);
  assign last_issue = issue && last_col && last_row;

  raster_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .COL_W  (COL_W),
    .ROW_W  (ROW_W)
  ) u_raster (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .en       (issue),
    .col      (col),
    .row      (row),
    .addr     (addr),
    .last_col (last_col),
    .last_row (last_row)
  );

  // Sequencer FSM plus the issue-stage registers. Issue flags are forced to
  // 0 on non-issue cycles so the data-stage copies are clean without gating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      iss_sol   <= 1'b0;
      iss_eol   <= 1'b0;
      iss_sof   <= 1'b0;
      iss_eof   <= 1'b0;
      iss_win   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= issue;
      iss_sol <= issue && (col == '0);
      iss_eol <= issue && last_col;
      iss_sof <= issue && (col == '0) && (row == '0);
      iss_eof <= issue && last_col && last_row;
      iss_win <= issue && (row >= ROW_W'(2)) && (col >= COL_W'(2));

      if (issue) begin
        rd_addr_q <= addr;
      end else if ((state == ST_IDLE) && bus.start) begin
        rd_addr_q <= '0;
      end

      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state  <= ST_RUN;
            busy_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (last_issue) begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
          end
        end
        ST_FLUSH: begin
          // PIPE_LAT+1 cycles after the final read: one for the RAM, then
          // the Sobel datapath latency.
          if (flush_cnt == FLUSH_LAST) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + FLUSH_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Data stage: tags line up with the cycle the RAM returns the pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid_q <= 1'b0;
      sol_q       <= 1'b0;
      eol_q       <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      pix_valid_q <= rd_en_q;
      sol_q       <= iss_sol;
      eol_q       <= iss_eol;
      sof_q       <= iss_sof;
      eof_q       <= iss_eof;
      win_q       <= iss_win;
    end
  end

  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.sol       = sol_q;
  assign bus.eol       = eol_q;
  assign bus.sof       = sof_q;
  assign bus.eof       = eof_q;
  assign bus.win_valid = win_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb_sobel_frame_ctrl
//   Self-checking bench for sobel_frame_ctrl. A behavioural model tracks
//   which pixel index should be read next and when the frame must complete;
//   a negedge process compares every DUT output against it each cycle.
//   Directed scenarios add literal expectations (latencies, per-frame counts).
module tb_sobel_frame_ctrl;
  import sobel_pkg::*;

  localparam int W  = IMG_W_DEF;
  localparam int H  = IMG_H_DEF;
  localparam int AW = ADDR_W_DEF;
  localparam int PL = PIPE_LAT_DEF;
  localparam int N  = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sobel_frame_ctrl_if #(.ADDR_W(AW)) bus ();

  sobel_frame_ctrl #(
    .IMG_W    (W),
    .IMG_H    (H),
    .ADDR_W   (AW),
    .PIPE_LAT (PL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 reading, 2 draining
  int         m_mode      = 0;
  int         m_next      = 0;
  int         m_done_at   = 0;
  bit         m_issue     = 1'b0;
  logic       exp_rd_en   = 1'b0;
  int         exp_rd_addr = 0;
  logic [5:0] exp_flags   = 6'd0;
  logic       exp_busy    = 1'b0;
  logic       exp_done    = 1'b0;

  // {pix_valid, sol, eol, sof, eof, win_valid} for a returned pixel index
  function automatic logic [5:0] flags_for(input int idx);
    int r, c;
    r = idx / W;
    c = idx % W;
    return {1'b1, (c == 0), (c == W - 1), (idx == 0), (idx == N - 1), (r >= 2 && c >= 2)};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode      = 0;
      m_next      = 0;
      exp_rd_en   = 1'b0;
      exp_rd_addr = 0;
      exp_flags   = 6'd0;
      exp_busy    = 1'b0;
      exp_done    = 1'b0;
    end else begin
      exp_flags = exp_rd_en ? flags_for(exp_rd_addr) : 6'd0;
      exp_done  = 1'b0;
      m_issue   = 1'b0;
      if (m_mode == 0) begin
        if (bus.start) begin
          m_mode  = 1;
          m_next  = 0;
          m_issue = bus.out_ready;
        end
      end else if (m_mode == 1) begin
        m_issue = bus.out_ready;
      end else if (cyc == m_done_at) begin
        m_mode   = 0;
        exp_done = 1'b1;
      end
      if (m_issue) begin
        exp_rd_en   = 1'b1;
        exp_rd_addr = m_next;
        if (m_next == N - 1) begin
          m_mode    = 2;
          // last data one cycle after the read, done PL cycles after that
          m_done_at = cyc + 1 + PL;
        end
        m_next++;
      end else begin
        exp_rd_en = 1'b0;
      end
      exp_busy = (m_mode != 0);
    end
  end

  // ---------------- per-cycle compare + event counters ----------------
  int pix_cnt = 0, win_cnt = 0, sol_cnt = 0, eol_cnt = 0;
  int sof_cnt = 0, eof_cnt = 0, done_cnt = 0;

  always @(negedge clk) begin
    check_output("rd_en", {31'd0, bus.rd_en}, {31'd0, exp_rd_en});
    if (exp_rd_en || rst)
      check_output("rd_addr", {{(32-AW){1'b0}}, bus.rd_addr}, rst ? 32'd0 : exp_rd_addr);
    check_output("pix_flags",
                 {26'd0, bus.pix_valid, bus.sol, bus.eol, bus.sof, bus.eof, bus.win_valid},
                 {26'd0, exp_flags});
    check_output("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
    check_output("done", {31'd0, bus.done}, {31'd0, exp_done});
    pix_cnt  += int'(bus.pix_valid);
    win_cnt  += int'(bus.win_valid);
    sol_cnt  += int'(bus.sol);
    eol_cnt  += int'(bus.eol);
    sof_cnt  += int'(bus.sof);
    eof_cnt  += int'(bus.eof);
    done_cnt += int'(bus.done);
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic rand_ready(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  task automatic apply_stimulus(input logic s, input logic r);
    @(negedge clk);
    bus.start     = s;
    bus.out_ready = r;
  endtask

  // Pulse start for one edge; t_start is the negedge cycle right after it.
  task automatic start_frame(input int pct, output int t_start);
    apply_stimulus(1'b1, rand_ready(pct));
    apply_stimulus(1'b0, rand_ready(pct));
    t_start = cyc;
  endtask

  task automatic run_to_done(input int pct, input int budget, output int t_done);
    bit found;
    found  = 1'b0;
    t_done = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (bus.done) begin
        found  = 1'b1;
        t_done = cyc;
      end
      bus.start     = 1'b0;
      bus.out_ready = rand_ready(pct);
    end
    check_output("done_seen", {31'd0, found}, 32'd1);
  endtask

  int t_start, t_done, t_d1, rise;
  int p0, w0, s0, e0, f0, l0, d0;
  int skid, low_left, dn;
  bit dropped, found, pending;

  task automatic snap();
    p0 = pix_cnt; w0 = win_cnt; s0 = sol_cnt; e0 = eol_cnt;
    f0 = sof_cnt; l0 = eof_cnt; d0 = done_cnt;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;

    // 1. reset with random inputs, then idle without start
    repeat (6) apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check_output("reset_rd_en", {31'd0, bus.rd_en}, 32'd0);
    check_output("reset_busy", {31'd0, bus.busy}, 32'd0);
    check_output("reset_pix", {31'd0, bus.pix_valid}, 32'd0);
    apply_stimulus(1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 1'($urandom_range(0, 1)));
      check_output("idle_rd_en", {31'd0, bus.rd_en}, 32'd0);
    end

    // 2. full frame, out_ready always high
    snap();
    start_frame(100, t_start);
    check_output("first_rd_en", {31'd0, bus.rd_en}, 32'd1);
    check_output("first_rd_addr", {{(32-AW){1'b0}}, bus.rd_addr}, 32'd0);
    run_to_done(100, N + 100, t_done);
    @(negedge clk);
    check_output("done_latency", t_done - t_start, 32'd1026);
    check_output("frame_pix", pix_cnt - p0, 32'd1024);
    check_output("frame_win", win_cnt - w0, 32'd900);
    check_output("frame_sol", sol_cnt - s0, 32'd32);
    check_output("frame_eol", eol_cnt - e0, 32'd32);
    check_output("frame_sof", sof_cnt - f0, 32'd1);
    check_output("frame_eof", eof_cnt - l0, 32'd1);
    check_output("frame_done", done_cnt - d0, 32'd1);

    // 3. backpressure: five not-ready edges right after address 40 issues
    snap();
    start_frame(100, t_start);
    dropped = 1'b0; low_left = 0; skid = 0; found = 1'b0; t_done = 0;
    for (int i = 0; i < N + 200 && !found; i++) begin
      @(negedge clk);
      if (low_left > 0) begin
        skid += int'(bus.pix_valid);
        low_left--;
      end
      if (bus.done) begin
        found  = 1'b1;
        t_done = cyc;
      end
      if (!dropped && bus.rd_en && bus.rd_addr == AW'(40)) begin
        dropped  = 1'b1;
        low_left = 5;
      end
      bus.out_ready = (low_left == 0);
    end
    @(negedge clk);
    check_output("bp_done_seen", {31'd0, found}, 32'd1);
    check_output("bp_skid_beats", skid, 32'd1);
    check_output("bp_done_latency", t_done - t_start, 32'd1031);
    check_output("bp_frame_pix", pix_cnt - p0, 32'd1024);
    check_output("bp_frame_done", done_cnt - d0, 32'd1);

    // 4. start pulses during RUN (at address 100) and during FLUSH are ignored
    snap();
    start_frame(100, t_start);
    found = 1'b0; pending = 1'b0;
    for (int i = 0; i < N + 100 && !found; i++) begin
      @(negedge clk);
      if (bus.done) found = 1'b1;
      if (pending) begin
        check_output("continue_addr", {{(32-AW){1'b0}}, bus.rd_addr}, 32'd101);
        pending = 1'b0;
      end
      if (bus.rd_en && bus.rd_addr == AW'(100)) begin
        bus.start = 1'b1;
        pending   = 1'b1;
      end else if (bus.rd_en && bus.rd_addr == AW'(N - 1)) begin
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      bus.out_ready = 1'b1;
    end
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 1'b1);
      check_output("no_restart", {31'd0, bus.rd_en}, 32'd0);
    end
    check_output("ign_done_seen", {31'd0, found}, 32'd1);
    check_output("ign_frame_done", done_cnt - d0, 32'd1);
    check_output("ign_frame_pix", pix_cnt - p0, 32'd1024);

    // 5. reset at address 500 aborts the frame without done
    snap();
    start_frame(100, t_start);
    found = 1'b0;
    for (int i = 0; i < N && !found; i++) begin
      @(negedge clk);
      if (bus.rd_en && bus.rd_addr == AW'(500)) begin
        found = 1'b1;
        #2 rst = 1'b1;
      end
    end
    check_output("abort_reached", {31'd0, found}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus($urandom_range(0, 1) == 1, 1'b1);
      check_output("abort_rd_en", {31'd0, bus.rd_en}, 32'd0);
      check_output("abort_pix", {31'd0, bus.pix_valid}, 32'd0);
      check_output("abort_busy", {31'd0, bus.busy}, 32'd0);
    end
    apply_stimulus(1'b0, 1'b1);
    rst = 1'b0;
    repeat (5) apply_stimulus(1'b0, 1'b1);
    check_output("abort_no_done", done_cnt - d0, 32'd0);

    snap();
    start_frame(70, t_start);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.pix_valid) begin
        found = 1'b1;
        check_output("restart_sof", {31'd0, bus.sof}, 32'd1);
      end
      bus.out_ready = rand_ready(70);
    end
    check_output("restart_pix_seen", {31'd0, found}, 32'd1);
    run_to_done(70, 4 * N, t_done);
    @(negedge clk);
    check_output("restart_frame_pix", pix_cnt - p0, 32'd1024);
    check_output("restart_frame_done", done_cnt - d0, 32'd1);

    // 6. back-to-back frames with start held high
    snap();
    apply_stimulus(1'b1, 1'b1);
    dn = 0; rise = 0; t_d1 = 0; found = 1'b0;
    for (int i = 0; i < 2 * (N + PL + 20) && !found; i++) begin
      @(negedge clk);
      if (bus.done) begin
        dn++;
        if (dn == 1) t_d1 = cyc;
        else begin
          found     = 1'b1;
          bus.start = 1'b0;
        end
      end
      if (dn == 1 && rise == 0 && bus.rd_en) rise = cyc;
    end
    @(negedge clk);
    check_output("b2b_two_done", dn, 32'd2);
    check_output("b2b_restart_gap", rise - t_d1, 32'd1);
    check_output("b2b_pix", pix_cnt - p0, 32'd2048);
    check_output("b2b_done", done_cnt - d0, 32'd2);

    // 7. random backpressure frames
    for (int f = 0; f < 2; f++) begin
      repeat ($urandom_range(1, 6)) apply_stimulus(1'b0, rand_ready(50));
      snap();
      start_frame(60, t_start);
      run_to_done(60, 4 * N, t_done);
      @(negedge clk);
      check_output("rand_frame_pix", pix_cnt - p0, 32'd1024);
      check_output("rand_frame_win", win_cnt - w0, 32'd900);
      check_output("rand_frame_done", done_cnt - d0, 32'd1);
    end

    repeat (3) apply_stimulus(1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
